// File: rtl/mem_arbiter.sv
// Three-requester arbiter (icache read, dcache read, dcache writeback) in front of a
// single-port line memory, one transaction outstanding, with icache starvation relief.
module mem_arbiter #(
    parameter int ARCH_BITS        = 32,
    parameter int MEMORY_LINE_BITS = 128,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARCH_BITS-1:0]        iReqAddr,
    input  logic                        iReq,
    output logic                        iValid,
    input  logic [ARCH_BITS-1:0]        dReqAddr,
    input  logic                        dReq,
    output logic                        dValid,
    input  logic [ARCH_BITS-1:0]        wAddr,
    input  logic                        wReq,
    input  logic [MEMORY_LINE_BITS-1:0] wLine,
    output logic                        wDone,
    output logic [MEMORY_LINE_BITS-1:0] lineOut,
    output logic [ARCH_BITS-1:0]        memAddr,
    output logic                        memReq,
    output logic                        memWe,
    output logic [MEMORY_LINE_BITS-1:0] memWLine,
    input  logic [MEMORY_LINE_BITS-1:0] memRLine,
    input  logic                        memAck
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {G_I, G_D, G_W} grant_t;

    localparam logic [2:0]           STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [ARCH_BITS-1:0] LINE_MASK  = ~ARCH_BITS'(15);

    state_t                      state, state_next;
    grant_t                      winner, grant;
    logic                        grant_valid;
    grant_t                      block_id;
    logic                        block_valid;
    logic [2:0]                  starve;
    logic [ARCH_BITS-1:0]        addr_q, addr_sel;
    logic [MEMORY_LINE_BITS-1:0] wline_q, line_q;
    logic                        elig_i, elig_d, elig_w;

    // The requester served last is still holding its level request for one cycle.
    assign elig_i = iReq && !(block_valid && block_id == G_I);
    assign elig_d = dReq && !(block_valid && block_id == G_D);
    assign elig_w = wReq && !(block_valid && block_id == G_W);

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        grant       = G_I;
        grant_valid = 1'b0;
        addr_sel    = iReqAddr;
        case (state)
            S_IDLE: begin
                if (elig_i && starve == STARVE_MAX) begin
                    grant_valid = 1'b1;
                    grant       = G_I;
                end else if (elig_w) begin
                    grant_valid = 1'b1;
                    grant       = G_W;
                end else if (elig_d) begin
                    grant_valid = 1'b1;
                    grant       = G_D;
                end else if (elig_i) begin
                    grant_valid = 1'b1;
                    grant       = G_I;
                end
                if (grant_valid) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memAck) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        case (grant)
            G_D:     addr_sel = dReqAddr;
            G_W:     addr_sel = wAddr;
            default: addr_sel = iReqAddr;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner      <= G_I;
            block_id    <= G_I;
            block_valid <= 1'b0;
            starve      <= '0;
            addr_q      <= '0;
            wline_q     <= '0;
            line_q      <= '0;
        end else begin
            block_valid <= (state == S_DONE);
            block_id    <= winner;
            if (state == S_IDLE && grant_valid) begin
                winner <= grant;
                addr_q <= addr_sel & LINE_MASK;
                if (grant == G_W) begin
                    wline_q <= wLine;
                end
                if (grant == G_I || !iReq) begin
                    starve <= '0;
                end else if (starve != 3'h7) begin
                    starve <= starve + 3'h1;
                end
            end
            if (state == S_WAIT && memAck && winner != G_W) begin
                line_q <= memRLine;
            end
        end
    end

    assign memReq   = (state == S_WAIT);
    assign memWe    = memReq && (winner == G_W);
    assign memAddr  = addr_q;
    assign memWLine = wline_q;
    assign lineOut  = line_q;
    assign iValid   = (state == S_DONE) && (winner == G_I);
    assign dValid   = (state == S_DONE) && (winner == G_D);
    assign wDone    = (state == S_DONE) && (winner == G_W);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for a single icache read, then
// hand-written sequences for priority, starvation, turnaround, reset and stray acks.
module tb_mem_arbiter;

    localparam int AB = 32;
    localparam int LB = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [AB-1:0] iReqAddr, dReqAddr, wAddr, memAddr;
    logic          iReq, dReq, wReq, iValid, dValid, wDone;
    logic          memReq, memWe, memAck;
    logic [LB-1:0] wLine, lineOut, memWLine, memRLine;

    int total  = 0;
    int passed = 0;

    mem_arbiter #(.ARCH_BITS(AB), .MEMORY_LINE_BITS(LB), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .iReqAddr(iReqAddr), .iReq(iReq), .iValid(iValid),
        .dReqAddr(dReqAddr), .dReq(dReq), .dValid(dValid),
        .wAddr(wAddr), .wReq(wReq), .wLine(wLine), .wDone(wDone),
        .lineOut(lineOut),
        .memAddr(memAddr), .memReq(memReq), .memWe(memWe), .memWLine(memWLine),
        .memRLine(memRLine), .memAck(memAck)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ireq;
        logic          ack;
        logic [LB-1:0] rline;
        logic          mreq;
        logic          mwe;
        logic [AB-1:0] maddr;
        logic [2:0]    pulses;  // {iValid, dValid, wDone}
        logic [LB-1:0] lout;
    } vec_t;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the grant, checks the held transaction, acks it and checks
    // the completion pulse. drop is {w, d, i}: requests lowered when the pulse is seen.
    task automatic serve(input string tag, input int who, input logic [AB-1:0] exp_addr,
                         input logic [LB-1:0] rdata, input logic [2:0] drop);
        int            n;
        logic [LB-1:0] prev_line;
        logic [LB-1:0] saved_wline;
        prev_line   = lineOut;
        saved_wline = wLine;
        n = 0;
        step();
        while (memReq !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check({tag, " memReq"}, LB'(memReq), LB'(1'b1));
        check({tag, " memAddr"}, LB'(memAddr), LB'(exp_addr));
        check({tag, " memWe"}, LB'(memWe), LB'(who == 2));
        wLine = ~saved_wline;
        step();
        check({tag, " memReq hold"}, LB'(memReq), LB'(1'b1));
        if (who == 2) begin
            check({tag, " memWLine"}, memWLine, saved_wline);
        end
        wLine    = saved_wline;
        memAck   = 1'b1;
        memRLine = rdata;
        step();
        memAck   = 1'b0;
        memRLine = '0;
        check({tag, " pulse"}, LB'({iValid, dValid, wDone}), LB'(3'b100 >> who));
        check({tag, " lineOut"}, lineOut, (who == 2) ? prev_line : rdata);
        if (drop[0]) iReq = 1'b0;
        if (drop[1]) dReq = 1'b0;
        if (drop[2]) wReq = 1'b0;
        step();
        check({tag, " idle memReq"}, LB'(memReq), LB'(1'b0));
        check({tag, " idle pulses"}, LB'({iValid, dValid, wDone}), LB'(3'b000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[7];
        logic [LB-1:0] a5;
        logic [LB-1:0] c3;
        a5 = {16{8'hA5}};
        c3 = {16{8'h3C}};

        rst = 1'b1; iReq = 0; dReq = 0; wReq = 0; memAck = 0;
        iReqAddr = '0; dReqAddr = '0; wAddr = '0; wLine = '0; memRLine = '0;
        step();
        step();
        check("reset memReq", LB'(memReq), LB'(1'b0));
        check("reset memWe", LB'(memWe), LB'(1'b0));
        check("reset memAddr", LB'(memAddr), '0);
        check("reset memWLine", memWLine, '0);
        check("reset lineOut", lineOut, '0);
        check("reset pulses", LB'({iValid, dValid, wDone}), '0);
        rst = 1'b0;

        // Single icache read: request at t, ack at t+3, iValid at t+4.
        vecs[0] = '{ireq: 0, ack: 0, rline: '0, mreq: 0, mwe: 0, maddr: 32'h0,        pulses: 3'b000, lout: '0};
        vecs[1] = '{ireq: 1, ack: 0, rline: '0, mreq: 1, mwe: 0, maddr: 32'h00001000, pulses: 3'b000, lout: '0};
        vecs[2] = '{ireq: 1, ack: 0, rline: '0, mreq: 1, mwe: 0, maddr: 32'h00001000, pulses: 3'b000, lout: '0};
        vecs[3] = '{ireq: 1, ack: 0, rline: '0, mreq: 1, mwe: 0, maddr: 32'h00001000, pulses: 3'b000, lout: '0};
        vecs[4] = '{ireq: 1, ack: 1, rline: a5, mreq: 0, mwe: 0, maddr: 32'h00001000, pulses: 3'b100, lout: a5};
        vecs[5] = '{ireq: 0, ack: 0, rline: '0, mreq: 0, mwe: 0, maddr: 32'h00001000, pulses: 3'b000, lout: a5};
        vecs[6] = '{ireq: 0, ack: 0, rline: '0, mreq: 0, mwe: 0, maddr: 32'h00001000, pulses: 3'b000, lout: a5};
        iReqAddr = 32'h00001004;
        for (int i = 0; i < 7; i++) begin
            iReq     = vecs[i].ireq;
            memAck   = vecs[i].ack;
            memRLine = vecs[i].rline;
            step();
            check($sformatf("vec%0d memReq", i), LB'(memReq), LB'(vecs[i].mreq));
            check($sformatf("vec%0d memWe", i), LB'(memWe), LB'(vecs[i].mwe));
            check($sformatf("vec%0d memAddr", i), LB'(memAddr), LB'(vecs[i].maddr));
            check($sformatf("vec%0d pulses", i), LB'({iValid, dValid, wDone}), LB'(vecs[i].pulses));
            check($sformatf("vec%0d lineOut", i), lineOut, vecs[i].lout);
        end
        memAck = 1'b0;

        // All three raised together: served w, d, i.
        wAddr = 32'h0000200F; dReqAddr = 32'h00003008; iReqAddr = 32'h00004004;
        wLine = {4{32'hDEADBEEF}};
        wReq = 1; dReq = 1; iReq = 1;
        serve("prio w", 2, 32'h00002000, c3, 3'b100);
        serve("prio d", 1, 32'h00003000, {16{8'h11}}, 3'b010);
        serve("prio i", 0, 32'h00004000, {16{8'h22}}, 3'b001);

        // w and d held continuously with iReq high: i forced after four non-i grants.
        wAddr = 32'h00005000; dReqAddr = 32'h00006000; iReqAddr = 32'h00007000;
        wLine = {4{32'h12345678}};
        wReq = 1; dReq = 1; iReq = 1;
        serve("starve w1", 2, 32'h00005000, '0, 3'b000);
        serve("starve d1", 1, 32'h00006000, {16{8'h33}}, 3'b000);
        serve("starve w2", 2, 32'h00005000, '0, 3'b000);
        serve("starve d2", 1, 32'h00006000, {16{8'h44}}, 3'b000);
        serve("starve i", 0, 32'h00007000, {16{8'h55}}, 3'b111);

        // dReq held through the first IDLE cycle after dValid: next grant goes to i.
        dReqAddr = 32'h00008008; iReqAddr = 32'h00009004;
        dReq = 1; iReq = 1;
        serve("turn d", 1, 32'h00008000, {16{8'h66}}, 3'b000);
        step();
        check("turn grant memReq", LB'(memReq), LB'(1'b1));
        check("turn grant memAddr", LB'(memAddr), LB'(32'h00009000));
        dReq = 0;
        memAck = 1; memRLine = {16{8'h77}};
        step();
        memAck = 0;
        check("turn i pulse", LB'({iValid, dValid, wDone}), LB'(3'b100));
        check("turn i lineOut", lineOut, {16{8'h77}});
        iReq = 0;
        step();
        step();
        check("turn no redo memReq", LB'(memReq), LB'(1'b0));
        step();
        check("turn no redo pulses", LB'({iValid, dValid, wDone, memReq}), LB'(4'b0000));

        // Reset while waiting; a late ack must be ignored.
        dReqAddr = 32'h0000A000;
        dReq = 1;
        step();
        check("rst wait memReq", LB'(memReq), LB'(1'b1));
        rst = 1; dReq = 0;
        step();
        rst = 0;
        check("rst memReq", LB'(memReq), LB'(1'b0));
        check("rst memAddr", LB'(memAddr), '0);
        memAck = 1; memRLine = {16{8'h99}};
        step();
        memAck = 0;
        check("rst late ack pulses", LB'({iValid, dValid, wDone, memReq}), LB'(4'b0000));
        check("rst late ack lineOut", lineOut, '0);
        step();
        check("rst after pulses", LB'({iValid, dValid, wDone, memReq}), LB'(4'b0000));

        // Stray ack in IDLE with no requests.
        memAck = 1; memRLine = {16{8'hEE}};
        step();
        memAck = 0;
        check("stray ack outputs", LB'({iValid, dValid, wDone, memReq, memWe}), LB'(5'b00000));
        check("stray ack lineOut", lineOut, '0);
        step();
        check("stray ack after", LB'({iValid, dValid, wDone, memReq}), LB'(4'b0000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ARCH_BITS, default 32, address width.
REQ-002 SHALL have parameter MEMORY_LINE_BITS, default 128, cache-line width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive lost arbitrations before the icache read is forced.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk input 1, clock; rst input 1, reset.
REQ-005 SHALL have ports iReqAddr input ARCH_BITS (icache read address), iReq input 1 (icache read request, level), iValid output 1 (icache line ready pulse).
REQ-006 SHALL have ports dReqAddr input ARCH_BITS (dcache read address), dReq input 1 (dcache read request, level), dValid output 1 (dcache line ready pulse).
REQ-007 SHALL have ports wAddr input ARCH_BITS (dcache writeback address), wReq input 1 (writeback request, level), wLine input MEMORY_LINE_BITS (writeback data), wDone output 1 (writeback complete pulse).
REQ-008 SHALL have port lineOut output MEMORY_LINE_BITS, the read line for whichever of iValid/dValid is pulsing.
REQ-009 SHALL have ports memAddr output ARCH_BITS, memReq output 1, memWe output 1, memWLine output MEMORY_LINE_BITS, memRLine input MEMORY_LINE_BITS, memAck input 1 (single-port memory; one-cycle completion pulse).

Function
REQ-010 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-011 In IDLE with at least one eligible request, SHALL latch the winner ID, its address with bits [3:0] cleared, and wLine if the winner is the write, then go to WAIT; otherwise SHALL stay in IDLE.
REQ-012 Priority SHALL be wReq > dReq > iReq, except that iReq wins when the starvation counter equals STARVE_LIMIT.
REQ-013 The starvation counter (3 bits, saturating) SHALL increment on each grant to w or d while iReq=1, and clear on a grant to i or on any grant made while iReq=0.
REQ-014 In WAIT, SHALL drive memReq=1 and hold memAddr, memWe (1 only for a write grant) and memWLine constant from the latched values.
REQ-015 In WAIT on memAck=1, SHALL register memRLine into lineOut (write grants leave lineOut unchanged) and go to DONE.
REQ-016 In DONE, SHALL pulse exactly one of iValid, dValid or wDone for one cycle, matching the latched winner, then go to IDLE.
REQ-017 In the first IDLE cycle after DONE, SHALL treat the just-served requester as ineligible (request-drop turnaround); the other requesters remain eligible.
REQ-018 Outside WAIT, memReq SHALL be 0; memAck SHALL be ignored outside WAIT.
REQ-019 Latency: request sampled in IDLE at cycle t -> memReq high from t+1; memAck at cycle t+k -> completion pulse at t+k+1.
REQ-020 Requests changing during WAIT or DONE SHALL NOT alter the latched transaction.
REQ-021 At most one transaction SHALL be outstanding; the three completion pulses SHALL be mutually exclusive.
REQ-022 With all requests low, the FSM SHALL stay in IDLE and all outputs SHALL hold their idle values.

Reset
REQ-023 On rst=1 at a clock edge, SHALL enter IDLE; memReq, memWe, iValid, dValid and wDone SHALL be 0; memAddr, memWLine and lineOut SHALL be 0; the starvation counter SHALL be 0.
REQ-024 A reset in WAIT or DONE SHALL abandon the transaction and produce no completion pulse; a memAck arriving after reset SHALL be ignored.

Verification
REQ-025 The bench SHALL cover: iReq=1 with iReqAddr=0x00001004, memAck 3 cycles later with memRLine=0xA5...A5 -> memAddr=0x00001000, memWe=0, iValid pulses once, and lineOut=0xA5...A5 in that cycle.
REQ-026 The bench SHALL cover: wReq, dReq and iReq all raised in the same cycle -> service order w, d, i; wDone, then dValid, then iValid; memWe=1 only during the write.
REQ-027 The bench SHALL cover: wReq/dReq kept high continuously with iReq=1 -> iReq is granted after exactly 4 non-i grants.
REQ-028 The bench SHALL cover: rst asserted during WAIT, memAck pulsed the next cycle -> FSM in IDLE, no completion pulse, memReq=0.
REQ-029 The bench SHALL cover: dReq held high one cycle past dValid while iReq=1 -> the next grant goes to i, and d is not double-served.
REQ-030 The bench SHALL cover: memAck pulsed while in IDLE with no requests -> no state change and no output pulse.
